seg_scan_driver: RTL and testbench

- Time-multiplexed driver for an 8-digit seven-segment display.
- Sits directly upstream of the 3-to-8 one-hot digit decoder. Its 3-bit digit select feeds the decoder's A (MSB), B, C (LSB) inputs.
- Also produces the segment pattern for the selected digit from a 32-bit hex value.
- Includes a frame-synchronous value update so a new value never tears mid-frame.

---
 rtl/seg_scan_driver.sv | 158 +++++++++++++++
 tb/tb_seg_scan_driver.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/seg_scan_driver.sv
// seg_scan_driver: time-multiplexed 8-digit seven-segment scanner.
// Drives the digit select of a downstream 3-to-8 decoder and the segment
// pattern of the selected digit. A new value is staged and only swapped into
// the display register on a frame boundary so a frame never shows two values.
//
// Handshake note: there is no valid/ready pair here. `load` is a one-cycle
// strobe that is always accepted; `sel_valid` qualifies sel/seg/dp and is
// meant to gate the decoder enable directly.
module seg_scan_driver #(
  parameter int CLK_DIV    = 50000,
  parameter int NUM_DIGITS = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        en,
  input  logic [31:0] value,
  input  logic        load,
  input  logic [7:0]  dp_mask,
  input  logic        blank_lz,
  output logic [2:0]  sel,
  output logic        sel_valid,
  output logic [6:0]  seg,
  output logic        dp,
  output logic        frame_done
);

  localparam int              PW         = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [PW-1:0]   PRESC_LAST = PW'(CLK_DIV - 1);
  localparam logic [2:0]      IDX_LAST   = 3'(NUM_DIGITS - 1);

  logic [PW-1:0] presc_q, presc_d;
  logic [2:0]    idx_q, idx_d;
  logic [31:0]   stage_q, stage_d;
  logic [31:0]   disp_q, disp_d;
  logic          pend_q, pend_d;
  logic [2:0]    sel_q, sel_d;
  logic          sel_valid_q, sel_valid_d;
  logic [6:0]    seg_q, seg_d;
  logic          dp_q, dp_d;
  logic          frame_done_q, frame_done_d;

  logic          tick;
  logic          frame_tick;
  logic [3:0]    nib;
  logic          upper_zero;
  logic          blank;

  // Hex nibble to {g,f,e,d,c,b,a} glyph.
  function automatic logic [6:0] hex_glyph(input logic [3:0] n);
    case (n)
      4'h0: hex_glyph = 7'h3F;
      4'h1: hex_glyph = 7'h06;
      4'h2: hex_glyph = 7'h5B;
      4'h3: hex_glyph = 7'h4F;
      4'h4: hex_glyph = 7'h66;
      4'h5: hex_glyph = 7'h6D;
      4'h6: hex_glyph = 7'h7D;
      4'h7: hex_glyph = 7'h07;
      4'h8: hex_glyph = 7'h7F;
      4'h9: hex_glyph = 7'h6F;
      4'hA: hex_glyph = 7'h77;
      4'hB: hex_glyph = 7'h7C;
      4'hC: hex_glyph = 7'h39;
      4'hD: hex_glyph = 7'h5E;
      4'hE: hex_glyph = 7'h79;
      default: hex_glyph = 7'h71;
    endcase
  endfunction

  // Next-state: prescaler, digit index, staging/display registers and outputs.
  // Outputs are computed from the next index/display so they change on the
  // same edge as the index itself.
  always_comb begin
    presc_d    = presc_q;
    idx_d      = idx_q;
    tick       = 1'b0;
    frame_tick = 1'b0;
    if (en) begin
      if (presc_q == PRESC_LAST) begin
        presc_d = '0;
        tick    = 1'b1;
      end else begin
        presc_d = presc_q + 1'b1;
      end
    end
    if (tick) begin
      if (idx_q == IDX_LAST) begin
        idx_d      = 3'd0;
        frame_tick = 1'b1;
      end else begin
        idx_d = idx_q + 3'd1;
      end
    end

    stage_d = load ? value : stage_q;
    pend_d  = pend_q | load;
    disp_d  = disp_q;
    // A load in the very cycle of the frame tick goes straight to display.
    if (frame_tick && (pend_q || load)) begin
      disp_d = load ? value : stage_q;
      pend_d = 1'b0;
    end

    nib        = disp_d[{idx_d, 2'b00} +: 4];
    upper_zero = 1'b1;
    for (int i = 0; i < 8; i++) begin
      if ((i < NUM_DIGITS) && (3'(i) >= idx_d) && (disp_d[4*i +: 4] != 4'h0)) begin
        upper_zero = 1'b0;
      end
    end
    blank = blank_lz && (idx_d != 3'd0) && upper_zero;

    sel_d        = idx_d;
    sel_valid_d  = 1'b0;
    seg_d        = 7'h00;
    dp_d         = 1'b0;
    frame_done_d = frame_tick;
    if (en) begin
      sel_valid_d = 1'b1;
      seg_d       = blank ? 7'h00 : hex_glyph(nib);
      dp_d        = dp_mask[idx_d];
    end
  end

  // State and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      presc_q      <= '0;
      idx_q        <= 3'd0;
      stage_q      <= 32'h0;
      disp_q       <= 32'h0;
      pend_q       <= 1'b0;
      sel_q        <= 3'd0;
      sel_valid_q  <= 1'b0;
      seg_q        <= 7'h00;
      dp_q         <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      presc_q      <= presc_d;
      idx_q        <= idx_d;
      stage_q      <= stage_d;
      disp_q       <= disp_d;
      pend_q       <= pend_d;
      sel_q        <= sel_d;
      sel_valid_q  <= sel_valid_d;
      seg_q        <= seg_d;
      dp_q         <= dp_d;
      frame_done_q <= frame_done_d;
    end
  end

  assign sel        = sel_q;
  assign sel_valid  = sel_valid_q;
  assign seg        = seg_q;
  assign dp         = dp_q;
  assign frame_done = frame_done_q;

endmodule

// File: tb/tb_seg_scan_driver.sv
// Bench for seg_scan_driver: two instances (8 digits / div 4 and 5 digits /
// div 3) share stimulus; each is compared every cycle with a reference model
// that derives slot position from the count of enabled cycles.
module tb_seg_scan_driver;

  localparam int CD0 = 4;
  localparam int ND0 = 8;
  localparam int CD1 = 3;
  localparam int ND1 = 5;

  // Clock / reset block
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic        en, load, blank_lz;
  logic [31:0] value;
  logic [7:0]  dp_mask;

  logic [2:0] sel_a, sel_b;
  logic       valid_a, valid_b;
  logic [6:0] seg_a, seg_b;
  logic       dp_a, dp_b;
  logic       fd_a, fd_b;

  seg_scan_driver #(.CLK_DIV(CD0), .NUM_DIGITS(ND0)) dut_a (
    .clk(clk), .rst_n(rst_n), .en(en), .value(value), .load(load),
    .dp_mask(dp_mask), .blank_lz(blank_lz), .sel(sel_a), .sel_valid(valid_a),
    .seg(seg_a), .dp(dp_a), .frame_done(fd_a)
  );

  seg_scan_driver #(.CLK_DIV(CD1), .NUM_DIGITS(ND1)) dut_b (
    .clk(clk), .rst_n(rst_n), .en(en), .value(value), .load(load),
    .dp_mask(dp_mask), .blank_lz(blank_lz), .sel(sel_b), .sel_valid(valid_b),
    .seg(seg_b), .dp(dp_b), .frame_done(fd_b)
  );

  logic [6:0] glyph_tbl [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                                 7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

  // Reference model state, one slot per instance
  int unsigned m_cnt   [2];
  logic [31:0] m_disp  [2];
  logic [31:0] m_stage [2];
  bit          m_pend  [2];
  logic [2:0]  e_sel   [2];
  logic        e_valid [2];
  logic [6:0]  e_seg   [2];
  logic        e_dp    [2];
  logic        e_fd    [2];

  int n_checks = 0;
  int n_errors = 0;

  // Scoreboard compare
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic void model_reset();
    for (int j = 0; j < 2; j++) begin
      m_cnt[j] = 0; m_disp[j] = 0; m_stage[j] = 0; m_pend[j] = 0;
      e_sel[j] = 0; e_valid[j] = 0; e_seg[j] = 0; e_dp[j] = 0; e_fd[j] = 0;
    end
  endfunction

  // One rising edge of the model: slot index = (enabled cycles / div) mod digits,
  // and a frame boundary is every div*digits enabled cycles.
  function automatic void model_edge(input int j);
    int cd, nd, idx;
    bit frame;
    logic [63:0] mask;
    logic [31:0] vis;
    cd = (j == 0) ? CD0 : CD1;
    nd = (j == 0) ? ND0 : ND1;
    frame = 0;
    if (en) begin
      m_cnt[j]++;
      frame = ((m_cnt[j] % (cd * nd)) == 0);
    end
    if (frame && (m_pend[j] || load)) begin
      m_disp[j] = load ? value : m_stage[j];
      m_pend[j] = 0;
      if (load) m_stage[j] = value;
    end else if (load) begin
      m_stage[j] = value;
      m_pend[j]  = 1;
    end
    idx = int'((m_cnt[j] / cd) % nd);
    e_sel[j] = 3'(idx);
    if (en) begin
      mask = (64'h1 << (4 * nd)) - 64'h1;
      vis  = m_disp[j] & mask[31:0];
      e_valid[j] = 1;
      if (blank_lz && idx != 0 && (vis >> (4 * idx)) == 0) e_seg[j] = 0;
      else e_seg[j] = glyph_tbl[(m_disp[j] >> (4 * idx)) & 32'hF];
      e_dp[j] = dp_mask[idx];
      e_fd[j] = frame;
    end else begin
      e_valid[j] = 0; e_seg[j] = 0; e_dp[j] = 0; e_fd[j] = 0;
    end
  endfunction

  task automatic compare_all();
    check("a_sel",   32'(sel_a),   32'(e_sel[0]));
    check("a_valid", 32'(valid_a), 32'(e_valid[0]));
    check("a_seg",   32'(seg_a),   32'(e_seg[0]));
    check("a_dp",    32'(dp_a),    32'(e_dp[0]));
    check("a_fd",    32'(fd_a),    32'(e_fd[0]));
    check("b_sel",   32'(sel_b),   32'(e_sel[1]));
    check("b_valid", 32'(valid_b), 32'(e_valid[1]));
    check("b_seg",   32'(seg_b),   32'(e_seg[1]));
    check("b_dp",    32'(dp_b),    32'(e_dp[1]));
    check("b_fd",    32'(fd_b),    32'(e_fd[1]));
  endtask

  // Driver tasks: inputs change on the falling edge only
  task automatic step();
    @(posedge clk);
    model_edge(0);
    model_edge(1);
    @(negedge clk);
    compare_all();
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic do_load(input logic [31:0] v);
    load = 1; value = v;
    step();
    load = 0;
  endtask

  // Asynchronous reset a little after the falling edge, checked before any clock edge.
  task automatic do_reset();
    #2 rst_n = 0;
    #1;
    check("rst_sel",   32'({sel_a, sel_b}),     32'h0);
    check("rst_valid", 32'({valid_a, valid_b}), 32'h0);
    check("rst_seg",   32'({seg_a, seg_b}),     32'h0);
    check("rst_dp_fd", 32'({dp_a, dp_b, fd_a, fd_b}), 32'h0);
    model_reset();
    @(negedge clk);
    rst_n = 1;
  endtask

  task automatic wait_sel_a(input logic [2:0] target);
    int n = 0;
    while (e_sel[0] != target && n < 100) begin
      step();
      n++;
    end
    check("sync_sel", 32'(sel_a), 32'(target));
  endtask

  function automatic logic [31:0] rand_value();
    logic [63:0] v;
    v = {32'h0, $urandom} >> (4 * $urandom_range(0, 8));
    return v[31:0];
  endfunction

  initial begin
    rst_n = 0; en = 0; load = 0; value = 0; dp_mask = 0; blank_lz = 0;
    model_reset();
    @(negedge clk);
    @(negedge clk);
    check("init_seg", 32'({seg_a, seg_b}), 32'h0);
    check("init_ctl", 32'({sel_a, sel_b, valid_a, valid_b, dp_a, dp_b, fd_a, fd_b}), 32'h0);
    rst_n = 1;

    // Basic scan: first frame shows 0s, loaded value from the next frame on
    en = 1;
    do_load(32'h7654_3210);
    run(80);

    // Mid-frame load at index 3
    wait_sel_a(3'd3);
    do_load(32'h0000_ABCD);
    run(80);

    // Leading-zero blanking
    blank_lz = 1;
    do_load(32'h0000_0050);
    run(70);
    do_load(32'h0000_0000);
    run(70);

    // Decimal points and an enable gap at index 4
    blank_lz = 0;
    dp_mask  = 8'h81;
    do_load(32'h1357_9BDF);
    run(40);
    wait_sel_a(3'd4);
    step();
    en = 0;
    run(10);
    en = 1;
    run(70);

    // Reset with a pending load
    run(5);
    do_load(32'hDEAD_BEEF);
    run(2);
    do_reset();
    run(40);

    // Randomized phase
    for (int c = 0; c < 2000; c++) begin
      load = ($urandom_range(0, 19) == 0);
      if (load) value = rand_value();
      if ($urandom_range(0, 39) == 0) en = ~en;
      if ($urandom_range(0, 99) == 0) blank_lz = $urandom_range(0, 1) == 1;
      if ($urandom_range(0, 99) == 0) dp_mask = 8'($urandom);
      if ($urandom_range(0, 699) == 0) do_reset();
      else step();
    end
    load = 0;

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
